i_decode: RTL and testbench
===========================

I_DECODE -- requirements
Module: i_decode

Interface
REQ-001 Parameter WORD, default 32: datapath word width; all word ports below are WORD bits.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-004 nPC  in  WORD  incremented PC from fetch.
REQ-005 IR  in  WORD  instruction from fetch.
REQ-006 Result  in  WORD  write-back data.
REQ-007 WriteAddress  in  5  write-back destination register.
REQ-008 RegWrite_in  in  1  write-back enable.
REQ-009 Outputs, all registered (ID/EX): nPCout WORD, A WORD, B WORD, SE WORD, RT 5, RD 5, ALUOp 2, ALUSrc 1, Branch 1, MemRead 1, MemWrite 1, MemtoReg 1, RegWrite 1, RegDst 1.

Function
REQ-010 Register file: 32 x WORD; register 0 always reads 0 and ignores writes.
REQ-011 Write: on a clk edge with reset high, RegWrite_in=1 and WriteAddress!=0, Result is written to WriteAddress.
REQ-012 On each clk edge with reset high, the following are captured (1-cycle latency):
- nPCout = nPC
- A = reg[IR[25:21]]
- B = reg[IR[20:16]]
- SE = IR[15:0] sign-extended to WORD
- RT = IR[20:16]
- RD = IR[15:11]
REQ-013 Control decode on opcode IR[31:26], fields in the order RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp:
- 0x00 R-type: 1,0,0,1,0,0,0,10
- 0x23 lw: 0,1,1,1,1,0,0,00
- 0x2B sw: 0,1,0,0,0,1,0,00
- 0x04 beq: 0,0,0,0,0,0,1,01
REQ-014 Any other opcode produces all control outputs 0 (bubble); data fields are still captured per REQ-012.
REQ-015 IR=0 (sll $0,$0,0) decodes as R-type; its write to register 0 has no effect.
REQ-016 There is no stall or enable input; the stage advances every clock.

Reset
REQ-017 While reset=0 at a clk edge, every output is cleared to 0 and all 32 registers are cleared to 0.
REQ-018 Reset has priority over a simultaneous register write; the write is discarded.
REQ-019 The first edge with reset=1 captures the current IR and nPC normally.

Configuration
REQ-020 Macro REGFILE_BYPASS_EN enables write-through forwarding.
- Defined: if RegWrite_in=1, WriteAddress!=0 and WriteAddress equals rs (IR[25:21]) or rt (IR[20:16]), then A or B captures Result in that same edge.
- Not defined: A and B capture the pre-write register contents; the new value becomes visible from the next edge onward.

Verification
REQ-021 Reset: hold reset=0 for 2 edges with IR=0x8C220004 -> all outputs 0; then read any register -> 0.
REQ-022 R-type: write reg2=5, reg3=7; IR=0x00430820 (add $1,$2,$3), nPC=0x10 -> next edge A=5, B=7, RT=3, RD=1, RegDst=1, RegWrite=1, ALUOp=10, nPCout=0x10.
REQ-023 lw/sw sign extension:
- IR=0x8C22FFFC (lw) -> SE=0xFFFFFFFC, ALUSrc=1, MemRead=1, MemtoReg=1, RegWrite=1.
- IR=0xAC220008 (sw) -> SE=8, MemWrite=1, RegWrite=0.
REQ-024 beq and illegal opcode:
- IR=0x10220003 -> Branch=1, ALUOp=01, SE=3.
- IR=0xFC000000 -> all control outputs 0.
REQ-025 Register 0: write Result=0xDEAD to WriteAddress=0, then decode rs=0 -> A=0.
REQ-026 Same-cycle write/read: Result=0x55 to reg4 while IR reads rs=4 -> A=0x55 with REGFILE_BYPASS_EN, old value without it; A=0x55 on the following edge in both builds.

Source files
------------

// File: rtl/i_decode.sv
// i_decode: ID stage with a 32 x WORD register file and an ID/EX register.
// In: clk, reset (sync, active-low), nPC, IR, Result, WriteAddress, RegWrite_in.
// Out (registered): nPCout, A, B, SE, RT, RD, ALUOp, ALUSrc, Branch, MemRead,
// MemWrite, MemtoReg, RegWrite, RegDst.
// Option: define REGFILE_BYPASS_EN for write-through of Result into A/B.
module i_decode #(
  parameter int WORD = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [WORD-1:0] nPC,
  input  logic [WORD-1:0] IR,
  input  logic [WORD-1:0] Result,
  input  logic [4:0]      WriteAddress,
  input  logic            RegWrite_in,
  output logic [WORD-1:0] nPCout,
  output logic [WORD-1:0] A,
  output logic [WORD-1:0] B,
  output logic [WORD-1:0] SE,
  output logic [4:0]      RT,
  output logic [4:0]      RD,
  output logic [1:0]      ALUOp,
  output logic            ALUSrc,
  output logic            Branch,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            MemtoReg,
  output logic            RegWrite,
  output logic            RegDst
);

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  logic [WORD-1:0] rf_q [32];
  logic [WORD-1:0] rf_d [32];

  logic [WORD-1:0] npc_q, npc_d;
  logic [WORD-1:0] a_q, a_d;
  logic [WORD-1:0] b_q, b_d;
  logic [WORD-1:0] se_q, se_d;
  logic [4:0]      rt_q, rt_d;
  logic [4:0]      rd_q, rd_d;
  ctrl_t           ctrl_q, ctrl_d;

  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       wr_hit;

  assign op     = IR[31:26];
  assign rs     = IR[25:21];
  assign rt     = IR[20:16];
  assign wr_hit = RegWrite_in && (WriteAddress != 5'd0);

  always_comb begin
    rf_d = rf_q;
    if (wr_hit) begin
      rf_d[WriteAddress] = Result;
    end
  end

  // Register 0 is forced to zero on read; wr_hit never targets it.
  always_comb begin
    a_d = (rs == 5'd0) ? '0 : rf_q[rs];
    b_d = (rt == 5'd0) ? '0 : rf_q[rt];
`ifdef REGFILE_BYPASS_EN
    if (wr_hit && (WriteAddress == rs)) begin
      a_d = Result;
    end
    if (wr_hit && (WriteAddress == rt)) begin
      b_d = Result;
    end
`endif
  end

  always_comb begin
    npc_d = nPC;
    se_d  = {{(WORD-16){IR[15]}}, IR[15:0]};
    rt_d  = rt;
    rd_d  = IR[15:11];
  end

  // Unknown opcodes fall to the default: an all-zero bubble.
  always_comb begin
    ctrl_d = '0;
    unique case (1'b1)
      (op == 6'h00): ctrl_d = 9'b1_0_0_1_0_0_0_10;
      (op == 6'h23): ctrl_d = 9'b0_1_1_1_1_0_0_00;
      (op == 6'h2B): ctrl_d = 9'b0_1_0_0_0_1_0_00;
      (op == 6'h04): ctrl_d = 9'b0_0_0_0_0_0_1_01;
      default:       ctrl_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
      npc_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      se_q   <= '0;
      rt_q   <= '0;
      rd_q   <= '0;
      ctrl_q <= '0;
    end else begin
      rf_q   <= rf_d;
      npc_q  <= npc_d;
      a_q    <= a_d;
      b_q    <= b_d;
      se_q   <= se_d;
      rt_q   <= rt_d;
      rd_q   <= rd_d;
      ctrl_q <= ctrl_d;
    end
  end

  assign nPCout   = npc_q;
  assign A        = a_q;
  assign B        = b_q;
  assign SE       = se_q;
  assign RT       = rt_q;
  assign RD       = rd_q;
  assign RegDst   = ctrl_q.reg_dst;
  assign ALUSrc   = ctrl_q.alu_src;
  assign MemtoReg = ctrl_q.mem_to_reg;
  assign RegWrite = ctrl_q.reg_write;
  assign MemRead  = ctrl_q.mem_read;
  assign MemWrite = ctrl_q.mem_write;
  assign Branch   = ctrl_q.branch;
  assign ALUOp    = ctrl_q.alu_op;

endmodule

// File: tb/tb_i_decode.sv
// tb_i_decode: directed + random checks of i_decode against an
// array-based register model and an opcode control table.
module tb_i_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] nPC, IR, Result;
  logic [4:0]  WriteAddress;
  logic        RegWrite_in;
  logic [31:0] nPCout, A, B, SE;
  logic [4:0]  RT, RD;
  logic [1:0]  ALUOp;
  logic        ALUSrc, Branch, MemRead, MemWrite;
  logic        MemtoReg, RegWrite, RegDst;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] m_reg [32];

  i_decode #(.WORD(32)) dut (
    .clk(clk), .reset(reset), .nPC(nPC), .IR(IR),
    .Result(Result), .WriteAddress(WriteAddress),
    .RegWrite_in(RegWrite_in), .nPCout(nPCout),
    .A(A), .B(B), .SE(SE), .RT(RT), .RD(RD),
    .ALUOp(ALUOp), .ALUSrc(ALUSrc), .Branch(Branch),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .RegDst(RegDst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Order: RegDst ALUSrc MemtoReg RegWrite MemRead MemWrite Branch ALUOp
  function automatic logic [8:0] ctrl_of(input logic [5:0] op);
    case (op)
      6'h00:   return {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10};
      6'h23:   return {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00};
      6'h2B:   return {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
      6'h04:   return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01};
      default: return 9'd0;
    endcase
  endfunction

  task automatic step(input logic rst, input logic [31:0] npc,
                      input logic [31:0] ir, input logic [31:0] res,
                      input logic [4:0] wa, input logic we);
    logic [31:0] e_npc, e_a, e_b, e_se;
    logic [4:0]  e_rt, e_rd;
    logic [8:0]  e_ctl, g_ctl;
    int rs, rt;
    reset = rst; nPC = npc; IR = ir;
    Result = res; WriteAddress = wa; RegWrite_in = we;
    rs = int'(ir[25:21]);
    rt = int'(ir[20:16]);
    if (!rst) begin
      e_npc = 0; e_a = 0; e_b = 0; e_se = 0;
      e_rt = 0; e_rd = 0; e_ctl = 0;
      for (int i = 0; i < 32; i++) m_reg[i] = 0;
    end else begin
      e_npc = npc;
      e_a = m_reg[rs];
      e_b = m_reg[rt];
`ifdef REGFILE_BYPASS_EN
      if (we && wa != 0 && int'(wa) == rs) e_a = res;
      if (we && wa != 0 && int'(wa) == rt) e_b = res;
`endif
      e_se = (ir[15] ? 32'hFFFF_0000 : 32'h0) | {16'h0, ir[15:0]};
      e_rt = ir[20:16];
      e_rd = ir[15:11];
      e_ctl = ctrl_of(ir[31:26]);
      if (we && wa != 0) m_reg[wa] = res;
    end
    @(posedge clk);
    #1;
    g_ctl = {RegDst, ALUSrc, MemtoReg, RegWrite,
             MemRead, MemWrite, Branch, ALUOp};
    chk("nPCout", nPCout, e_npc);
    chk("A", A, e_a);
    chk("B", B, e_b);
    chk("SE", SE, e_se);
    chk("RT", {27'd0, RT}, {27'd0, e_rt});
    chk("RD", {27'd0, RD}, {27'd0, e_rd});
    chk("ctrl", {23'd0, g_ctl}, {23'd0, e_ctl});
  endtask

  initial begin
    logic [31:0] r, npc, ir, res;
    logic [5:0]  op;
    for (int i = 0; i < 32; i++) m_reg[i] = 0;
    // Reset for two edges with a lw in IR.
    step(1'b0, 32'h44, 32'h8C22_0004, 32'h1, 5'd2, 1'b1);
    step(1'b0, 32'h44, 32'h8C22_0004, 32'h1, 5'd2, 1'b1);
    // Registers read as zero after reset; first edge decodes normally.
    step(1'b1, 32'h04, 32'h00A6_0000, 32'h0, 5'd0, 1'b0);
    // R-type add $1,$2,$3 with reg2=5, reg3=7.
    step(1'b1, 32'h08, 32'h0, 32'd5, 5'd2, 1'b1);
    step(1'b1, 32'h0C, 32'h0, 32'd7, 5'd3, 1'b1);
    step(1'b1, 32'h10, 32'h0043_0820, 32'h0, 5'd0, 1'b0);
    chk("rtype_A", A, 32'd5);
    chk("rtype_B", B, 32'd7);
    chk("rtype_npc", nPCout, 32'h10);
    // lw / sw / beq / illegal.
    step(1'b1, 32'h14, 32'h8C22_FFFC, 32'h0, 5'd0, 1'b0);
    chk("lw_SE", SE, 32'hFFFF_FFFC);
    step(1'b1, 32'h18, 32'hAC22_0008, 32'h0, 5'd0, 1'b0);
    chk("sw_SE", SE, 32'd8);
    step(1'b1, 32'h1C, 32'h1022_0003, 32'h0, 5'd0, 1'b0);
    chk("beq_br", {31'd0, Branch}, 32'd1);
    step(1'b1, 32'h20, 32'hFC00_0000, 32'h0, 5'd0, 1'b0);
    // Write to reg0 is ignored.
    step(1'b1, 32'h24, 32'h0, 32'hDEAD, 5'd0, 1'b1);
    step(1'b1, 32'h28, 32'h0000_0000, 32'h0, 5'd0, 1'b0);
    chk("reg0_A", A, 32'd0);
    // Same-edge write/read of reg4, then visible next edge.
    step(1'b1, 32'h2C, 32'h0080_0000, 32'h55, 5'd4, 1'b1);
    step(1'b1, 32'h30, 32'h0080_0000, 32'h0, 5'd0, 1'b0);
    chk("reg4_next", A, 32'h55);
    // Reset beats a simultaneous write.
    step(1'b0, 32'h34, 32'h0080_0000, 32'h99, 5'd5, 1'b1);
    step(1'b1, 32'h38, 32'h00A5_0000, 32'h0, 5'd0, 1'b0);
    chk("rst_wr_A", A, 32'd0);
    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      r = $urandom();
      case ($urandom_range(0, 4))
        0: op = 6'h00;
        1: op = 6'h23;
        2: op = 6'h2B;
        3: op = 6'h04;
        default: op = r[31:26];
      endcase
      ir  = {op, r[25:0]};
      npc = $urandom();
      res = $urandom();
      step(($urandom_range(0, 39) != 0), npc, ir, res,
           5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
